// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART definitions: parity encodings, FSM state encodings
//             and the clocks-per-bit helper. Used by the TX and RX blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity selector values for the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Frame-level state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    // Number of sys_clk cycles per serial bit
    function automatic int baud_cnt_max(input int clk_hz, input int bps);
        return clk_hz / bps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_gen
//  Brief    : Bit-period counter. Runs while enabled, held at zero otherwise,
//             and flags the last clock of every bit period with o_bit_end.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CNT_MAX = 5208
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_en,
    output logic o_bit_end
);

    localparam int               c_cnt_w    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CNT_MAX - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Free-running bit counter; wrapping (not reloading) keeps back-to-back frames drift-free
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_end = i_en && (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_cfg
//  Brief    : Parametrised UART transmitter with valid/ready input and a
//             one-entry holding buffer for gap-free back-to-back frames.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [DATA_BITS-1:0] pi_data,
    input  logic                 pi_valid,
    output logic                 pi_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int         BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam logic [3:0] c_last_data  = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_last_stop  = 4'(STOP_BITS - 1);

    // Reject unsupported configurations at elaboration
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (BAUD_CNT_MAX < 2) begin : g_err_baud
        $error("uart_tx_cfg: CLK_FREQ/UART_BPS must be at least 2");
    end

    uart_state_t           r_state;
    uart_state_t           w_state_nxt;
    logic [DATA_BITS-1:0]  r_buf;
    logic                  r_buf_full;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_nxt;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            w_bit_cnt_nxt;
    logic                  r_par_bit;
    logic                  w_par_of_buf;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_bit_end;

    assign w_accept     = pi_valid & ~r_buf_full;
    assign w_par_of_buf = (PARITY == PAR_ODD) ? ~^r_buf : ^r_buf;

    uart_baud_gen #(
        .CNT_MAX   (BAUD_CNT_MAX)
    ) u_baud_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_en      (r_state != ST_IDLE),
        .o_bit_end (w_bit_end)
    );

    // Holding buffer: filled on handshake, freed when the frame engine takes it
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf      <= pi_data;
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    // Frame engine registers: state, shift register, bit counter, parity, line
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx      <= w_tx_nxt;
            if (w_load) begin
                r_par_bit <= w_par_of_buf;
            end
        end
    end

    // Next-state and next-line logic; a load from the buffer can happen from IDLE
    // or directly at the end of STOP so consecutive frames abut
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tx_nxt      = r_tx;
        w_load        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                w_load   = r_buf_full;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_DATA;
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_last_data) begin
                        w_bit_cnt_nxt = '0;
                        if (PARITY != PAR_NONE) begin
                            w_state_nxt = ST_PAR;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end
            end
            ST_PAR: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_STOP;
                    w_tx_nxt      = 1'b1;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_last_stop) begin
                        w_bit_cnt_nxt = '0;
                        if (r_buf_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
        if (w_load) begin
            w_state_nxt   = ST_START;
            w_tx_nxt      = 1'b0;
            w_shift_nxt   = r_buf;
            w_bit_cnt_nxt = '0;
        end
    end

    assign pi_ready = ~r_buf_full;
    assign busy     = (r_state != ST_IDLE) | r_buf_full;
    assign tx       = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_cfg
//  Brief    : Scoreboard bench for uart_tx_cfg across six frame formats at
//             10 clocks per bit. Stimulus pushes expected bytes; a per-DUT
//             line decoder reconstructs frames and pops/compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 5_000_000;
    localparam int BIT_CLKS = 10;
    localparam int NCFG     = 6;
    localparam int DB [NCFG] = '{8, 8, 8, 7, 8, 8};
    localparam int PA [NCFG] = '{0, 2, 1, 0, 1, 2};
    localparam int SB [NCFG] = '{1, 1, 1, 2, 2, 2};

    typedef struct {
        logic [8:0] data;
        logic       par;
    } exp_t;

    logic sys_clk  = 1'b0;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;

    always #10 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s [u%0d] cycle %0d: got %0h, expected %0h",
                     name, inst, cyc, act, req);
        end
    endtask

    task automatic mark_done();
        n_done++;
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int         DBI    = DB[gi];
        localparam int         PAI    = PA[gi];
        localparam int         SBI    = SB[gi];
        localparam int         NBITS  = 1 + DBI + ((PAI != 0) ? 1 : 0) + SBI;
        localparam logic [8:0] c_mask = 9'((1 << DBI) - 1);

        logic           rst_n    = 1'b0;
        logic [DBI-1:0] pi_data  = '0;
        logic           pi_valid = 1'b0;
        logic           pi_ready;
        logic           tx;
        logic           busy;
        exp_t           exp_q[$];
        int             start_q[$];

        uart_tx_cfg #(
            .CLK_FREQ  (CLK_FREQ),
            .UART_BPS  (UART_BPS),
            .DATA_BITS (DBI),
            .PARITY    (PAI),
            .STOP_BITS (SBI)
        ) u_dut (
            .sys_clk   (sys_clk),
            .sys_rst_n (rst_n),
            .pi_data   (pi_data),
            .pi_valid  (pi_valid),
            .pi_ready  (pi_ready),
            .tx        (tx),
            .busy      (busy)
        );

        function automatic logic calc_par(input logic [8:0] d);
            logic x;
            x = ^(d & c_mask);
            if (PAI == PAR_ODD)  return ~x;
            if (PAI == PAR_EVEN) return x;
            return 1'b0;
        endfunction

        // Offer one byte; returns the cycle of the accepting edge
        task automatic send(input logic [8:0] d, input logic par,
                            input bit push, output int acc);
            int w;
            w        = 0;
            pi_data  = d[DBI-1:0];
            pi_valid = 1'b1;
            while (!pi_ready && w < 2000) begin
                tick();
                w++;
            end
            check("handshake_timeout", gi, 32'(w >= 2000), 32'd0);
            tick();
            acc      = cyc;
            pi_valid = 1'b0;
            if (push) exp_q.push_back('{data: d & c_mask, par: par});
        endtask

        task automatic rand_burst(input int n);
            int         a;
            logic [8:0] d;
            for (int k = 0; k < n; k++) begin
                d = 9'($urandom_range(0, 255)) & c_mask;
                send(d, calc_par(d), 1'b1, a);
            end
        endtask

        task automatic finish_cfg();
            int w;
            w = 0;
            while (exp_q.size() != 0 && w < 3000) begin
                tick();
                w++;
            end
            check("scoreboard_drained", gi, 32'(exp_q.size()), 32'd0);
            mark_done();
        endtask

        // Line decoder: mid-bit sampling, bit-edge spacing, frame compare
        initial begin : decoder
            int         st;
            int         bi;
            logic       prev;
            logic       ab;
            logic [8:0] d;
            exp_t       e;
            forever begin
                tick();
                if (rst_n && tx === 1'b0) begin
                    st   = cyc;
                    ab   = 1'b0;
                    prev = 1'b0;
                    d    = '0;
                    start_q.push_back(st);
                    for (int off = 1; off < NBITS * BIT_CLKS; off++) begin
                        tick();
                        if (!rst_n) begin
                            ab = 1'b1;
                            break;
                        end
                        if (tx !== prev) begin
                            check("bit_spacing", gi, 32'(off % BIT_CLKS), 32'd0);
                            prev = tx;
                        end
                        if (off % BIT_CLKS == BIT_CLKS / 2) begin
                            bi = off / BIT_CLKS;
                            if (bi == 0) begin
                                check("start_bit", gi, 32'(tx), 32'd0);
                            end else if (bi <= DBI) begin
                                d[bi-1] = tx;
                            end else if (PAI != 0 && bi == DBI + 1) begin
                                if (exp_q.size() != 0)
                                    check("parity_bit", gi, 32'(tx), 32'(exp_q[0].par));
                            end else begin
                                check("stop_bit", gi, 32'(tx), 32'd1);
                            end
                        end
                    end
                    if (!ab) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", gi, 32'(d), 32'h1ff);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_data", gi, 32'(d), 32'(e.data));
                        end
                    end
                end
            end
        end

        if (gi == 0) begin : g_t_8n1
            initial begin : stim
                int a0, a1, a2, n0;
                // Reset state
                repeat (3) tick();
                check("rst_tx", gi, 32'(tx), 32'd1);
                check("rst_busy", gi, 32'(busy), 32'd0);
                check("rst_ready", gi, 32'(pi_ready), 32'd1);
                rst_n = 1'b1;
                repeat (5) tick();
                check("idle_tx", gi, 32'(tx), 32'd1);

                // 8N1 0xA5: start one clock after acceptance, 100-clock frame
                send(9'h0A5, 1'b0, 1'b1, a0);
                check("t1_tx_before_start", gi, 32'(tx), 32'd1);
                check("t1_ready_full", gi, 32'(pi_ready), 32'd0);
                check("t1_busy", gi, 32'(busy), 32'd1);
                tick();
                check("t1_start_low", gi, 32'(tx), 32'd0);
                check("t1_ready_freed", gi, 32'(pi_ready), 32'd1);
                wait_cyc(a0 + 100);
                check("t1_busy_last_clk", gi, 32'(busy), 32'd1);
                tick();
                check("t1_busy_fall", gi, 32'(busy), 32'd0);

                // Back-to-back 0x01, 0x80, 0xFF with pi_valid held
                repeat (20) tick();
                n0 = start_q.size();
                send(9'h001, 1'b0, 1'b1, a0);
                send(9'h080, 1'b0, 1'b1, a1);
                check("t4_second_accept", gi, 32'(a1 - a0), 32'd2);
                check("t4_ready_low", gi, 32'(pi_ready), 32'd0);
                send(9'h0FF, 1'b0, 1'b1, a2);
                check("t4_third_accept", gi, 32'(a2 - a0), 32'd102);
                wait_cyc(a0 + 300);
                check("t4_busy_end_m1", gi, 32'(busy), 32'd1);
                tick();
                check("t4_busy_end", gi, 32'(busy), 32'd0);
                check("t4_gap_1_2", gi, 32'(start_q[n0+1] - start_q[n0]), 32'd100);
                check("t4_gap_2_3", gi, 32'(start_q[n0+2] - start_q[n0+1]), 32'd100);

                // Reset during data bit 3 of 0x3C with 0x80 buffered
                repeat (20) tick();
                send(9'h03C, 1'b0, 1'b0, a0);
                send(9'h080, 1'b0, 1'b0, a1);
                check("t5_buffer_full", gi, 32'(pi_ready), 32'd0);
                wait_cyc(a0 + 46);
                rst_n    = 1'b0;
                pi_data  = '1;
                pi_valid = 1'b1;
                tick();
                check("t5_rst_tx", gi, 32'(tx), 32'd1);
                check("t5_rst_busy", gi, 32'(busy), 32'd0);
                check("t5_rst_ready", gi, 32'(pi_ready), 32'd1);
                tick();
                rst_n    = 1'b1;
                pi_valid = 1'b0;
                tick();
                check("t5_no_accept_in_rst", gi, 32'(busy), 32'd0);
                send(9'h05A, 1'b0, 1'b1, a2);
                wait_cyc(a2 + 101);
                check("t5_after_frame_idle", gi, 32'(busy), 32'd0);

                rand_burst(10);
                finish_cfg();
            end
        end else if (gi == 1) begin : g_t_8e1
            initial begin : stim
                int a;
                repeat (3) tick();
                rst_n = 1'b1;
                repeat (5) tick();
                // Even parity of 0x07 (three ones) is 1; 11-bit frame
                send(9'h007, 1'b1, 1'b1, a);
                wait_cyc(a + 110);
                check("t2_busy_last_clk", gi, 32'(busy), 32'd1);
                tick();
                check("t2_busy_fall", gi, 32'(busy), 32'd0);
                rand_burst(8);
                finish_cfg();
            end
        end else if (gi == 2) begin : g_t_8o1
            initial begin : stim
                int a;
                repeat (3) tick();
                rst_n = 1'b1;
                repeat (5) tick();
                // Odd parity: 0x07 -> 0, 0x00 -> 1
                send(9'h007, 1'b0, 1'b1, a);
                send(9'h000, 1'b1, 1'b1, a);
                rand_burst(8);
                finish_cfg();
            end
        end else if (gi == 3) begin : g_t_7n2
            initial begin : stim
                int a;
                repeat (3) tick();
                rst_n = 1'b1;
                repeat (5) tick();
                // 7N2 0x55: 1+7+2 bits = 100 clocks
                send(9'h055, 1'b0, 1'b1, a);
                wait_cyc(a + 100);
                check("t3_busy_last_clk", gi, 32'(busy), 32'd1);
                tick();
                check("t3_busy_fall", gi, 32'(busy), 32'd0);
                rand_burst(8);
                finish_cfg();
            end
        end else begin : g_t_rand
            initial begin : stim
                repeat (3) tick();
                rst_n = 1'b1;
                repeat (5) tick();
                rand_burst(8);
                finish_cfg();
            end
        end
    end

    initial begin : main
        int w;
        w = 0;
        while (n_done < NCFG && w < 20000) begin
            tick();
            w++;
        end
        check("all_configs_done", -1, 32'(n_done), 32'(NCFG));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
